// File: rtl/coin_acceptor.sv
// Coin acceptor front end: sensor sync/debounce, pulse-width qualification, coin FIFO.
// Optional macro COIN_REJECT_CNT_EN adds an 8-bit saturating reject counter output.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_PULSE  = 8,
  parameter int MAX_PULSE  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_5,
  input  logic       sense_10,
  input  logic       coin_ready,
  output logic [1:0] coin,
  output logic       coin_valid,
  output logic       reject,
  output logic       fifo_full
`ifdef COIN_REJECT_CNT_EN
  ,
  output logic [7:0] reject_cnt
`endif
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int WW = $clog2(MAX_PULSE + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, MEASURE, REJECT_WAIT} state_t;

  logic [1:0]    raw, sync_meta, sync_q, filt;
  logic [DW-1:0] deb_cnt [2];
  logic          f5, f10;

  state_t        state, state_n;
  logic [1:0]    coin_type, coin_type_n;
  logic [WW-1:0] width, width_n;
  logic          active, other;
  logic          push_req, rej_fsm, reject_q;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, drop;

  assign raw = {sense_10, sense_5};
  assign f5  = filt[0];
  assign f10 = filt[1];

  // Bit 0 is the 5 rs sensor, bit 1 the 10 rs sensor; a level change needs DEB_CYCLES disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta  <= '0;
      sync_q     <= '0;
      filt       <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          filt[i]    <= sync_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign active = coin_type[0] ? f5  : f10;
  assign other  = coin_type[0] ? f10 : f5;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      coin_type <= 2'b00;
      width     <= '0;
      reject_q  <= 1'b0;
    end else begin
      state     <= state_n;
      coin_type <= coin_type_n;
      width     <= width_n;
      reject_q  <= rej_fsm | drop;
    end
  end

  // Width counts filtered-high cycles including the IDLE cycle that saw the rise.
  always_comb begin
    state_n     = state;
    coin_type_n = coin_type;
    width_n     = width;
    push_req    = 1'b0;
    rej_fsm     = 1'b0;
    unique case (state)
      IDLE: begin
        if (f5 && f10) begin
          state_n = REJECT_WAIT;
          rej_fsm = 1'b1;
        end else if (f5 ^ f10) begin
          state_n     = MEASURE;
          coin_type_n = f5 ? 2'b01 : 2'b10;
          width_n     = WW'(1);
        end
      end
      MEASURE: begin
        if (!active) begin
          if ((width >= WW'(MIN_PULSE)) && (width <= WW'(MAX_PULSE))) push_req = 1'b1;
          else rej_fsm = 1'b1;
          if (other) begin
            state_n = REJECT_WAIT;
            rej_fsm = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (other) begin
          state_n = REJECT_WAIT;
          rej_fsm = 1'b1;
        end else if (width != WW'(MAX_PULSE + 1)) begin
          width_n = width + 1'b1;
        end
      end
      REJECT_WAIT: begin
        if (!f5 && !f10) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign coin_valid = (count != '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = coin_valid && coin_ready;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign coin       = coin_valid ? mem[rd_ptr] : 2'b00;
  assign reject     = reject_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= coin_type;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef COIN_REJECT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) reject_cnt <= 8'd0;
    else if (reject_q && (reject_cnt != 8'hFF)) reject_cnt <= reject_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that sits directly upstream of the vending FSM and drives its 2-bit coin input.
- Synchronises and debounces two raw coin-slot sensors (5 rs, 10 rs).
- Qualifies each sensor pulse by width and rejects illegal or simultaneous insertions.
- Buffers accepted coins in a small FIFO and presents them as codes 01 = 5 rs, 10 = 10 rs, 00 = no coin, with a valid/ready handshake.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before a filtered sensor level changes.
- MIN_PULSE, 8: minimum filtered pulse width (cycles) for a legal coin.
- MAX_PULSE, 64: maximum filtered pulse width (cycles) for a legal coin.
- FIFO_DEPTH, 4: coin buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- sense_5  input  1  raw 5 rs slot sensor, asynchronous
- sense_10  input  1  raw 10 rs slot sensor, asynchronous
- coin_ready  input  1  downstream accepts the current coin this cycle
- coin  output  2  head coin code; 00 when FIFO empty
- coin_valid  output  1  FIFO non-empty
- reject  output  1  one-cycle pulse per rejected insertion
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries

Behaviour:
Reset:
- State IDLE, FIFO empty, sync flops, filtered levels and all counters cleared.
- coin = 00, coin_valid = 0, reject = 0, fifo_full = 0.
- Reset mid-pulse discards the pulse in progress. A sensor still high after reset is re-filtered and measured from the point its filtered level rises; a resulting short pulse is rejected.

Sensor front end:
- Each sensor passes through a 2-flop synchroniser, then a debounce filter.
- Filtered level takes the new synchronised value only after DEB_CYCLES consecutive cycles of disagreement; any agreement cycle clears the counter.
- f5 and f10 denote the filtered levels.

FSM (registered state, one transition per clock):
- IDLE:
  - f5 xor f10 -> MEASURE; latch type (01 for f5, 10 for f10); width = 1.
  - f5 and f10 both high -> REJECT_WAIT.
  - Otherwise stay.
- MEASURE:
  - Active sensor still high, other low: width increments, saturating at MAX_PULSE+1.
  - Other sensor rises -> REJECT_WAIT.
  - Active sensor falls: if MIN_PULSE <= width <= MAX_PULSE, push the latched code, else pulse reject. Next state is IDLE, or REJECT_WAIT if the other sensor is high in that cycle.
- REJECT_WAIT:
  - Pulses reject on the entry cycle only.
  - Stays until f5 and f10 are both low, then IDLE.

FIFO:
- Push with FIFO full: coin dropped, reject pulses 1 cycle, contents unchanged.
- Pop occurs when coin_valid and coin_ready.
- Push and pop in the same cycle while full: both take effect; count unchanged, new coin at tail.
- Push while empty: no bypass. coin_valid rises the cycle after the push.
- Pointers wrap modulo FIFO_DEPTH; the count register is log2(FIFO_DEPTH)+1 bits wide.
- coin and coin_valid are registered-path outputs derived from FIFO state.

Latency:
- Raw sensor fall to coin_valid high is at most DEB_CYCLES+4 cycles when the FIFO is empty.

Optional Feature:
Macro COIN_REJECT_CNT_EN.
- Defined: adds output port reject_cnt [7:0].
  - Increments on every reject pulse and saturates at 255.
  - Cleared only by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- sense_5 high 20 cycles, coin_ready=1 -> exactly one coin=01 with coin_valid for one cycle, reject never high.
- sense_10 high 5 cycles -> no coin_valid, one reject pulse. sense_10 high 100 cycles -> one reject pulse.
- sense_5 high 20 cycles with sense_10 rising at cycle 10 and held 20 cycles -> one reject pulse, no coin pushed until both sensors are low for DEB_CYCLES.
- 3-cycle glitches on sense_5 (below DEB_CYCLES) -> no FSM activity, no reject, no coin.
- coin_ready=0, five legal 10 rs pulses -> fifo_full=1 after the 4th, reject on the 5th. Then coin_ready=1 -> four consecutive 10 codes, then coin=00 and coin_valid=0.
- rst asserted mid-MEASURE on a legal 5 rs pulse -> no coin emitted, all outputs 0 the cycle after rst. With COIN_REJECT_CNT_EN defined, reject_cnt returns to 0.
